mem16x8_ctrl: RTL

Burst controller that sits directly upstream of the 16x8 register-file memory (`mem16x8`) and drives its `we`/`addr`/`data` inputs. It accepts write and read commands through a command handshake. Write bursts stream bytes in through a valid/ready port into consecutive memory locations; read bursts stream bytes from consecutive locations out through a valid/ready port. It accounts for the memory's registered read address, so read data appears one cycle after the address is driven.

---
 rtl/mem16x8_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem16x8_ctrl.sv
// Burst controller for the 16x8 register-file memory: write bursts stream bytes in,
// read bursts stream bytes out, allowing for the memory's registered read address.
module mem16x8_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [3:0] cmd_base,
    input  logic [3:0] cmd_len,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_data,
    input  logic [7:0] mem_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned AW = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RD_ADDR = 2'd2,
        S_RD_DATA = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    // Next-state and datapath update; cmd_* is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    ptr_d   = cmd_base;
                    cnt_d   = cmd_len;
                    state_d = cmd_rd ? S_RD_ADDR : S_WRITE;
                end
            end
            S_WRITE: begin
                if (in_valid) begin
                    if (cnt_q == AW'(0)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                        cnt_d = cnt_q - AW'(1);
                    end
                end
            end
            S_RD_ADDR: begin
                state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (rd_ready) begin
                    if (cnt_q == AW'(0)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d   = ptr_q + AW'(1);
                        cnt_d   = cnt_q - AW'(1);
                        state_d = S_RD_ADDR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Outputs decode the state register; ptr stays on the address bus in RD_DATA
    // so the memory's address register holds the byte under backpressure.
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_WRITE);
    assign mem_we    = (state_q == S_WRITE) && in_valid;
    assign mem_addr  = ptr_q;
    assign mem_data  = in_data;
    assign rd_valid  = (state_q == S_RD_DATA);
    assign rd_data   = mem_out;
    assign done      = done_q;

endmodule
